mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, meaning max BUSY cycles without m_ack (legal range 1..65535).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_req  input  1  fetch-stage read request, held until i_ack.
REQ-007 SHALL have port i_addr  input  AW  fetch address (PCF).
REQ-008 SHALL have port i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port i_rdata  output  DW  fetched instruction, valid with i_ack.
REQ-010 SHALL have ports d_req/d_we  input  1 each  mem-stage request held until d_ack; write enable.
REQ-011 SHALL have ports d_addr  input  AW, d_wdata  input  DW  data address (ALUResultM); store data (WriteDataM).
REQ-012 SHALL have ports d_ack  output  1, d_rdata  output  DW  completion pulse; load data.
REQ-013 SHALL have ports m_req/m_we  output  1 each, m_addr  output  AW, m_wdata  output  DW  shared single-port memory request.
REQ-014 SHALL have ports m_ack  input  1, m_rdata  input  DW  memory completion; read data valid with m_ack.
REQ-015 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-017 IDLE: if any request pending, SHALL latch winner id, address, we (0 for fetch), wdata at the clock edge and enter BUSY; otherwise stay IDLE.
REQ-018 Default arbitration: d_req wins over i_req when both are asserted.
REQ-019 BUSY: m_req SHALL be 1 with m_addr/m_we/m_wdata driven from latched registers, stable for the whole state.
REQ-020 BUSY with m_ack=1: SHALL capture m_rdata (0 if write) into the winner's rdata register and enter RESP.
REQ-021 RESP: winner's ack SHALL be 1 for exactly this one cycle; the other ack SHALL be 0; requests SHALL be ignored; next state IDLE.
REQ-022 Minimum latency: req sampled at edge N, m_req high in cycle N..N+1, ack high in cycle after m_ack sampled (3 cycles req-to-ack at zero memory wait).
REQ-023 m_req SHALL be 0 in IDLE and RESP; m_ack outside BUSY SHALL be ignored.
REQ-024 Timeout: a 16-bit counter SHALL clear on BUSY entry and increment per BUSY cycle with m_ack=0; on reaching TIMEOUT_CYC, SHALL enter RESP with rdata=0 and set err.
REQ-025 err SHALL remain 1 until reset; later transactions SHALL proceed normally.
REQ-026 i_rdata/d_rdata SHALL hold their last value until overwritten by the next response for that port.
REQ-027 A requester dropping req mid-transaction SHALL NOT abort it; the transaction and ack complete.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and set m_req, m_we, i_ack, d_ack, err to 0; m_addr, m_wdata, i_rdata, d_rdata and the timeout counter to 0.
REQ-029 Reset asserted mid-BUSY SHALL abandon the transaction with no ack issued.
REQ-030 Last-grant register SHALL reset to "fetch".

Configuration
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN: when defined, simultaneous i_req and d_req SHALL grant the port not granted last; when undefined, data always wins (REQ-018).
REQ-032 Last-grant register SHALL update on every grant in both builds.

Verification
REQ-033 i_req=1, i_addr=0x100, m_ack asserted in first BUSY cycle, m_rdata=0x00500093 -> m_addr=0x100, m_we=0; i_ack one cycle later with i_rdata=0x00500093; total 3 cycles.
REQ-034 d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, m_ack after 4 wait cycles -> m_we=1 stable for 5 BUSY cycles; d_ack pulse; d_rdata=0.
REQ-035 i_req and d_req both held for 3 transactions -> default build: D,D,D; MEM_ARB_ROUND_ROBIN_EN build: D,I,D.
REQ-036 TIMEOUT_CYC=8, m_ack tied 0, i_req=1 -> i_ack after 8 BUSY cycles, i_rdata=0, err=1 and held; next transaction with m_ack completes normally, err stays 1.
REQ-037 rst asserted in BUSY cycle 2 of a data read -> same cycle m_req=0, no d_ack, err=0; after release, pending i_req served from IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle for mem_arbiter: fetch port, data port and the shared memory port.
// slave  : seen from the arbiter.
// master : seen from the environment driving requests and the memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch port
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  // data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  // shared memory port
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;
  // sticky timeout flag
  logic          err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch requester and a
// data requester. One transaction at a time: IDLE -> BUSY -> RESP -> IDLE.
// A BUSY phase without m_ack for TIMEOUT_CYC cycles completes with zero data
// and sets the sticky err flag.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN -- when defined, a tie
// between fetch and data goes to the port not granted last; otherwise data
// always wins a tie.
module mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic          win_data_q, win_data_d;    // 1: data port owns the transaction
  logic          last_data_q, last_data_d;  // 1: last grant went to data
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          any_req;
  logic          tie_to_data;
  logic          pick_data;
  logic          fin;
  logic [DW-1:0] rsp;

  // Arbitration: who gets the grant if a request is taken this cycle.
  always_comb begin
    any_req = bus.i_req | bus.d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_to_data = ~last_data_q;
`else
    tie_to_data = 1'b1;
`endif
    pick_data = bus.d_req & (~bus.i_req | tie_to_data);
  end

  // Next-state and datapath updates for the three-state transaction FSM.
  always_comb begin
    state_d     = state_q;
    win_data_d  = win_data_q;
    last_data_d = last_data_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fin         = 1'b0;
    rsp         = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_data_d  = pick_data;
          last_data_d = pick_data;
          addr_d      = pick_data ? bus.d_addr : bus.i_addr;
          we_d        = pick_data & bus.d_we;
          // fetches never write; keep the bus quiet with zero write data
          wdata_d     = pick_data ? bus.d_wdata : '0;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (bus.m_ack) begin
          fin = 1'b1;
          rsp = we_q ? '0 : bus.m_rdata;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == TO_LIM) begin
            fin   = 1'b1;
            err_d = 1'b1;
          end
        end
        if (fin) begin
          state_d = RESP;
          if (win_data_q) d_rdata_d = rsp;
          else            i_rdata_d = rsp;
        end
      end
      RESP: begin
        // requests are not looked at here; the ack pulse is this cycle
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_data_q  <= 1'b0;
      last_data_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_data_q  <= win_data_d;
      last_data_q <= last_data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Outputs decode straight from registered state, so they drop with reset.
  always_comb begin
    bus.m_req   = (state_q == BUSY);
    bus.m_we    = (state_q == BUSY) & we_q;
    bus.m_addr  = addr_q;
    bus.m_wdata = wdata_q;
    bus.i_ack   = (state_q == RESP) & ~win_data_q;
    bus.d_ack   = (state_q == RESP) &  win_data_q;
    bus.i_rdata = i_rdata_q;
    bus.d_rdata = d_rdata_q;
    bus.err     = err_q;
  end

endmodule
